// File: rtl/branch_unit_if.sv
// Operand/result bundle between the operand buses, the sequencer and branch_unit.
// Issue: the unit accepts valid_in only on an edge where flush is low; each accepted issue returns one valid_out pulse two cycles later.
interface branch_unit_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 valid_in;
  logic [2:0]           mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 flush;
  logic                 cnt_load;
  logic [CNT_WIDTH-1:0] cnt_value;
  logic                 valid_out;
  logic                 taken;
  logic                 eq;
  logic                 lt;
  logic                 ltu;
  logic [CNT_WIDTH-1:0] cnt_out;

  modport master (
    output valid_in, mode, a, b, flush, cnt_load, cnt_value,
    input  valid_out, taken, eq, lt, ltu, cnt_out
  );

  modport slave (
    input  valid_in, mode, a, b, flush, cnt_load, cnt_value,
    output valid_out, taken, eq, lt, ltu, cnt_out
  );
endinterface

// File: rtl/branch_unit.sv
// branch_unit: two-stage branch-condition evaluator with an optional hardware loop counter.
// Define BRANCH_UNIT_LOOP_EN to build the loop counter, cnt_load/cnt_value and DJNZ mode.
module branch_unit #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  branch_unit_if.slave bus
);
  localparam logic [2:0] MODE_EQ     = 3'b000;
  localparam logic [2:0] MODE_NE     = 3'b001;
  localparam logic [2:0] MODE_LT     = 3'b010;
  localparam logic [2:0] MODE_GE     = 3'b011;
  localparam logic [2:0] MODE_LTU    = 3'b100;
  localparam logic [2:0] MODE_GEU    = 3'b101;
  localparam logic [2:0] MODE_DJNZ   = 3'b110;
  localparam logic [2:0] MODE_ALWAYS = 3'b111;

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       mode_q;
  logic             s1_accept;
  logic             s2_fire;

  logic valid_out_q, taken_q, eq_q, lt_q, ltu_q;
  logic eq_d, lt_d, ltu_d, taken_d, djnz_taken;

  assign s1_accept = bus.valid_in & ~bus.flush;
  assign s2_fire   = s1_valid_q & ~bus.flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= MODE_EQ;
    end else begin
      s1_valid_q <= s1_accept;
      if (s1_accept) begin
        a_q    <= bus.a;
        b_q    <= bus.b;
        mode_q <= bus.mode;
      end
    end
  end

  // Flags are produced for every mode so the PC-select logic can use them freely.
  always_comb begin
    eq_d    = (a_q == b_q);
    lt_d    = ($signed(a_q) < $signed(b_q));
    ltu_d   = (a_q < b_q);
    taken_d = 1'b0;
    case (mode_q)
      MODE_EQ:     taken_d = eq_d;
      MODE_NE:     taken_d = ~eq_d;
      MODE_LT:     taken_d = lt_d;
      MODE_GE:     taken_d = ~lt_d;
      MODE_LTU:    taken_d = ltu_d;
      MODE_GEU:    taken_d = ~ltu_d;
      MODE_DJNZ:   taken_d = djnz_taken;
      MODE_ALWAYS: taken_d = 1'b1;
      default:     taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out_q <= 1'b0;
      taken_q     <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
    end else begin
      valid_out_q <= s2_fire;
      if (s2_fire) begin
        taken_q <= taken_d;
        eq_q    <= eq_d;
        lt_q    <= lt_d;
        ltu_q   <= ltu_d;
      end
    end
  end

`ifdef BRANCH_UNIT_LOOP_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_dec;

  // DJNZ decides on the pre-edge count; a coincident load overrides the decrement.
  assign cnt_dec    = cnt_q - CNT_WIDTH'(1);
  assign djnz_taken = (cnt_dec != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_load) begin
      cnt_d = bus.cnt_value;
    end else if (s2_fire && (mode_q == MODE_DJNZ)) begin
      cnt_d = cnt_dec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.cnt_out = cnt_q;
`else
  logic unused_loop;
  assign unused_loop = ^{bus.cnt_load, bus.cnt_value};
  assign djnz_taken  = 1'b0;
  assign bus.cnt_out = '0;
`endif

  assign bus.valid_out = valid_out_q;
  assign bus.taken     = taken_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.ltu       = ltu_q;
endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised, pipelined branch-condition unit for the NISC datapath. Compares two WIDTH-bit operands under a selectable condition (equality, signed/unsigned magnitude, always) and owns a hardware loop counter for decrement-and-branch. Results are registered with a valid flag two cycles after issue, and a flush input squashes in-flight evaluations when the sequencer redirects. It sits between the operand buses and the program-counter select logic.

## Interface

- WIDTH, 8, operand width in bits (≥2)
- CNT_WIDTH, 8, loop-counter width in bits (≥1)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- valid_in  input  1  issue strobe; operands and mode sampled when 1
- mode  input  3  000 EQ, 001 NE, 010 LT (signed), 011 GE (signed), 100 LTU, 101 GEU, 110 DJNZ, 111 ALWAYS
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- flush  input  1  squash all in-flight evaluations
- cnt_load  input  1  load loop counter from cnt_value
- cnt_value  input  CNT_WIDTH  loop-counter load value
- valid_out  output  1  result valid this cycle (single-cycle pulse per issue)
- taken  output  1  branch condition result
- eq  output  1  registered a == b
- lt  output  1  registered signed a < b
- ltu  output  1  registered unsigned a < b
- cnt_out  output  CNT_WIDTH  current loop-counter value

## Operation

- Stage 1 (S1): on an edge with valid_in=1 and flush=0, capture a, b, mode; s1_valid←1. Otherwise s1_valid←0.
- Stage 2 (S2, outputs): on an edge with s1_valid=1 and flush=0, register eq, lt, ltu, taken from S1 contents; valid_out←1. Otherwise valid_out←0; eq/lt/ltu/taken hold previous values.
- taken per mode: EQ eq; NE !eq; LT lt; GE !lt; LTU ltu; GEU !ltu; ALWAYS 1; DJNZ (count−1) != 0 using the counter value before this edge.
- Signed compare: two's complement on full WIDTH; unsigned compare zero-extended. eq/lt/ltu computed for every mode, including DJNZ/ALWAYS.
- Loop counter: decremented by 1 on the S2 edge of a DJNZ evaluation; wraps modulo 2^CNT_WIDTH (0 → all-ones, taken=1).
- Simultaneous cnt_load and DJNZ S2 edge: taken uses pre-load count; counter ← cnt_value (load wins, no decrement).
- flush: at the edge where flush=1, s1_valid←0 and valid_out←0; an S1 DJNZ killed by flush does not decrement. flush with valid_in=1: input dropped. flush does not affect cnt_load.
- Back-to-back issue: one evaluation per cycle, full throughput; consecutive DJNZ see sequential counter values.

## Timing

- Latency: valid_in at edge N → valid_out/taken/flags valid in cycle after edge N+1 (2 cycles).
- cnt_out reflects counter register directly; update visible the cycle after the load/decrement edge.
- Reset (asynchronous, immediate): s1_valid=0, valid_out=0, taken=0, eq=0, lt=0, ltu=0, counter=0, cnt_out=0. Reset mid-operation discards all in-flight issues; no valid_out follows.
- First usable issue: edge after reset deasserts.

## Configuration

- BRANCH_UNIT_LOOP_EN defined: loop counter, cnt_load/cnt_value and DJNZ mode behave as above.
- Not defined: no counter register; cnt_out tied to 0; cnt_load/cnt_value ignored; DJNZ evaluates taken=0 (valid_out and flags still produced normally).

## Test plan

- WIDTH=8: issue EQ a=0x5A b=0x5A at edge 0 → cycle 2: valid_out=1, taken=1, eq=1, lt=0, ltu=0; valid_out=0 in cycle 3.
- Issue LT a=0x80 b=0x01 then LTU same operands back-to-back → consecutive results taken=1 (lt=1, ltu=0) then taken=0.
- cnt_load 3, then three consecutive DJNZ → taken 1,1,0; cnt_out 2,1,0; fourth DJNZ at 0 → taken=1, cnt_out=0xFF.
- DJNZ reaching S2 in same cycle as cnt_load 0x10 with count 1 → taken=0, cnt_out=0x10 next cycle.
- Issue GE, assert flush one cycle later → no valid_out; DJNZ in flushed S1 leaves cnt_out unchanged; reset asserted mid-pipeline → all outputs 0 immediately, no later valid_out.
- Macro undefined: cnt_load 5 then DJNZ → valid_out=1, taken=0, cnt_out=0.
